hood_mode_ctrl: RTL
===================

HOOD_MODE_CTRL -- requirements
Module: hood_mode_ctrl

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
  TICKS_PER_SEC, 100, clk_100Hz cycles per second.
  L3_SECS, 60, level-3 run time before auto-drop to level 2.
  RET_SECS, 60, fan run-on time after exit from level 3.
  CLEAN_SECS, 180, self-clean duration.
  MENU_SECS, 10, menu inactivity timeout.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
  clk_100Hz  in  1  system clock, 100 Hz.
  reset  in  1  asynchronous, active-high.
  power_on  in  1  level, 1 = appliance on.
  btn_menu  in  1  one-cycle pulse, debounced upstream.
  btn_l1  in  1  one-cycle pulse.
  btn_l2  in  1  one-cycle pulse.
  btn_l3  in  1  one-cycle pulse.
  btn_clean  in  1  one-cycle pulse.
  state  out  2  00 idle, 01 working, 11 cleaning; feeds the work-time counter.
  fan_level  out  2  0 off, 1..3 fan speed.
  countdown  out  8  seconds remaining in a timed mode, else 0.
  l3_used  out  1  level 3 already used this power cycle.
  clean_done  out  1  one-cycle pulse at clean completion.

Function
REQ-003 SHALL implement FSM states OFF, STANDBY, MENU, L1, L2, L3, RET and CLEAN, with all outputs registered.
REQ-004 SHALL force OFF on any edge where power_on=0, overriding all buttons; it SHALL clear l3_used, countdown and the prescaler.
REQ-005 SHALL go OFF->STANDBY on the first edge where power_on=1.
REQ-006 SHALL go STANDBY->MENU on btn_menu and ignore other buttons in STANDBY.
REQ-007 In MENU: btn_l1->L1, btn_l2->L2, btn_l3->L3 only if l3_used=0 (else ignored), btn_clean->CLEAN, btn_menu->STANDBY.
REQ-008 In MENU with no button for MENU_SECS seconds, the FSM SHALL return to STANDBY.
REQ-009 SHALL use button priority btn_menu > btn_clean > btn_l3 > btn_l2 > btn_l1 when several pulses coincide.
REQ-010 L1 and L2: btn_l1/btn_l2 SHALL switch between them, btn_menu SHALL go to STANDBY, and btn_l3 and btn_clean SHALL be ignored.
REQ-011 Entering L3 SHALL set l3_used=1 (sticky until OFF or reset); after L3_SECS the FSM SHALL go to L2; btn_menu in L3 SHALL go to RET.
REQ-012 RET SHALL keep fan_level=3 for RET_SECS and then go to STANDBY; all buttons SHALL be ignored in RET.
REQ-013 CLEAN SHALL run CLEAN_SECS and then go to STANDBY with clean_done=1 for exactly that cycle; all buttons SHALL be ignored in CLEAN.
REQ-014 SHALL map state as: OFF, STANDBY and MENU -> 00; L1, L2, L3 and RET -> 01; CLEAN -> 11.
REQ-015 SHALL map fan_level as: L1=1, L2=2, L3 and RET=3, all others=0.
REQ-016 Prescaler: 7-bit counter 0..TICKS_PER_SEC-1; sec_tick SHALL assert when it equals TICKS_PER_SEC-1, and it SHALL wrap to 0.
REQ-017 The prescaler SHALL clear on every state entry, so the first second of a timed state is a full TICKS_PER_SEC cycles.
REQ-018 On entering L3, RET, CLEAN or MENU, countdown SHALL load the matching *_SECS value and decrement by 1 on each sec_tick.
REQ-019 On a sec_tick with countdown=1, the timed transition SHALL take effect on that same edge, and countdown SHALL load 0 (or the new state's value).
REQ-020 Exact dwell SHALL be N*TICKS_PER_SEC cycles for N=*_SECS; countdown SHALL never underflow below 0.
REQ-021 Any accepted button in MENU SHALL reload the MENU timeout, including a btn_l3 that is rejected.
REQ-022 Latency: a button pulse on edge k SHALL make state, fan_level and countdown reflect the new mode at edge k; no extra pipeline stage is allowed.

Reset
REQ-023 reset=1 SHALL asynchronously set: FSM=OFF, state=00, fan_level=0, countdown=0, l3_used=0, clean_done=0, prescaler=0.
REQ-024 Reset asserted mid-operation (e.g. in CLEAN with countdown=90) SHALL abort immediately with no clean_done pulse.
REQ-025 After reset release with power_on=1, the FSM SHALL reach STANDBY on the first edge.

Verification
REQ-026 Power-up, menu, btn_l1, then btn_l2 -> state 01, fan_level 1 then 2, countdown 0 throughout.
REQ-027 MENU, btn_l3 -> fan_level 3, countdown 60; after 6000 cycles fan_level=2 and l3_used=1; a second MENU+btn_l3 is rejected and the FSM stays in MENU.
REQ-028 L3 at countdown 40, btn_menu -> RET, countdown 60, fan_level 3; after 6000 cycles STANDBY, fan_level 0.
REQ-029 MENU, btn_clean -> state 11, countdown 180; at cycle 18000 STANDBY with clean_done high for 1 cycle.
REQ-030 btn_menu and btn_l1 in the same cycle while in MENU -> STANDBY; power_on dropped while in L2 -> OFF next edge and l3_used cleared.
REQ-031 MENU idle for 999 cycles -> still MENU; idle for 1000 cycles -> STANDBY.

Source files
------------

// File: rtl/hood_mode_ctrl.sv
// Cooker-hood mode controller: menu, three fan levels, level-3 run-on and self-clean.
// Timed modes count whole seconds from a 100 Hz prescaler that restarts on every mode entry.
module hood_mode_ctrl #(
  parameter int TICKS_PER_SEC = 100,
  parameter int L3_SECS       = 60,
  parameter int RET_SECS      = 60,
  parameter int CLEAN_SECS    = 180,
  parameter int MENU_SECS     = 10
) (
  input  logic       clk_100Hz,
  input  logic       reset,
  input  logic       power_on,
  input  logic       btn_menu,
  input  logic       btn_l1,
  input  logic       btn_l2,
  input  logic       btn_l3,
  input  logic       btn_clean,
  output logic [1:0] state,
  output logic [1:0] fan_level,
  output logic [7:0] countdown,
  output logic       l3_used,
  output logic       clean_done
);

  typedef enum logic [2:0] {
    S_OFF, S_STBY, S_MENU, S_L1,
    S_L2, S_L3, S_RET, S_CLEAN
  } st_e;

  st_e        st_q, st_d;
  logic [6:0] presc_q, presc_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] state_q, state_d;
  logic [1:0] fan_q, fan_d;
  logic       l3_q, l3_d;
  logic       done_q, done_d;
  logic       reload;
  logic       sec_tick;
  logic       expire;
  logic       entry;

  assign sec_tick = (presc_q == 7'(TICKS_PER_SEC - 1));
  assign expire   = sec_tick && (cnt_q == 8'd1);

  always_ff @(posedge clk_100Hz or posedge reset) begin
    if (reset) begin
      st_q    <= S_OFF;
      presc_q <= '0;
      cnt_q   <= '0;
      state_q <= '0;
      fan_q   <= '0;
      l3_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      fan_q   <= fan_d;
      l3_q    <= l3_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    reload = 1'b0;
    if (!power_on) begin
      st_d = S_OFF;
    end else begin
      unique case (st_q)
        S_OFF:  st_d = S_STBY;
        S_STBY: if (btn_menu) st_d = S_MENU;
        S_MENU: begin
          if (btn_menu)                st_d = S_STBY;
          else if (btn_clean)          st_d = S_CLEAN;
          else if (btn_l3 && !l3_q)    st_d = S_L3;
          else if (btn_l2)             st_d = S_L2;
          else if (btn_l1)             st_d = S_L1;
          else if (btn_l3)             reload = 1'b1;
          else if (expire)             st_d = S_STBY;
        end
        S_L1: begin
          if (btn_menu)    st_d = S_STBY;
          else if (btn_l2) st_d = S_L2;
        end
        S_L2: begin
          if (btn_menu)    st_d = S_STBY;
          else if (btn_l1) st_d = S_L1;
        end
        S_L3: begin
          if (btn_menu)    st_d = S_RET;
          else if (expire) st_d = S_L2;
        end
        S_RET:   if (expire) st_d = S_STBY;
        S_CLEAN: if (expire) st_d = S_STBY;
        default: st_d = S_OFF;
      endcase
    end
  end

  // Outputs are derived from the next state so a button shows on the same edge.
  always_comb begin
    entry   = (st_d != st_q);
    presc_d = presc_q + 7'd1;
    cnt_d   = cnt_q;
    state_d = 2'b00;
    fan_d   = 2'd0;
    l3_d    = l3_q;
    done_d  = (st_q == S_CLEAN) && (st_d == S_STBY);

    if (!power_on || entry || reload || sec_tick) presc_d = '0;

    if (entry || reload) begin
      unique case (st_d)
        S_MENU:  cnt_d = 8'(MENU_SECS);
        S_L3:    cnt_d = 8'(L3_SECS);
        S_RET:   cnt_d = 8'(RET_SECS);
        S_CLEAN: cnt_d = 8'(CLEAN_SECS);
        default: cnt_d = 8'd0;
      endcase
    end else if (sec_tick && cnt_q != 8'd0) begin
      cnt_d = cnt_q - 8'd1;
    end

    unique case (st_d)
      S_L1:    begin state_d = 2'b01; fan_d = 2'd1; end
      S_L2:    begin state_d = 2'b01; fan_d = 2'd2; end
      S_L3:    begin state_d = 2'b01; fan_d = 2'd3; end
      S_RET:   begin state_d = 2'b01; fan_d = 2'd3; end
      S_CLEAN: state_d = 2'b11;
      default: state_d = 2'b00;
    endcase

    if (st_d == S_OFF)     l3_d = 1'b0;
    else if (st_d == S_L3) l3_d = 1'b1;
  end

  assign state      = state_q;
  assign fan_level  = fan_q;
  assign countdown  = cnt_q;
  assign l3_used    = l3_q;
  assign clean_done = done_q;

endmodule
